// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
// Holds the sequencer state enum, the reference truth tables for common gates,
// and a saturating increment helper used by the error counter.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  // Expected y per input vector, bit index = {a,b}.
  localparam logic [3:0] TRUTH_NAND = 4'b0111;
  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;
  localparam logic [3:0] TRUTH_NOR  = 4'b0001;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Bundle between the control register block, the BIST sequencer and the gate under test.
// Ports: start/passes request in; busy/done/pass/fail_map/err_count status out;
// a/b stimulus to the gate and y back from it. slave = sequencer, master = control side + gate.
interface gate_bist_ctrl_if #(
  parameter int PASS_W = 8
);
  logic              start;
  logic [PASS_W-1:0] passes;
  logic              busy;
  logic              done;
  logic              pass;
  logic [3:0]        fail_map;
  logic [7:0]        err_count;
  logic              a;
  logic              b;
  logic              y;

  modport master (
    output start, passes, y,
    input  busy, done, pass, fail_map, err_count, a, b
  );

  modport slave (
    input  start, passes, y,
    output busy, done, pass, fail_map, err_count, a, b
  );
endinterface

// File: rtl/bist_settle_timer.sv
// Loadable 4-bit down-counter timing the gate settle window.
// Ports: clk/rst_n; load with load_val; dec steps down (stops at 0);
// expired is high while the count sits at 1, i.e. during the last wait cycle.
module bist_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       expired
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign expired = (count == 4'd1);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for a 2-input combinational gate: sweeps {a,b} through 00,01,10,11
// for a programmable number of passes, samples y after a settle window, checks against TRUTH.
// Ports: clk, rst_n (async, active-low); bus (slave) carries start/passes, status and a/b/y.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TRUTH_NAND,
  parameter int         SETTLE = 2,   // legal 1..15
  parameter int         PASS_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_bist_ctrl_if.slave bus
);

  localparam logic [PASS_W-1:0] ONE      = PASS_W'(1);
  localparam logic [3:0]        SETTLE_V = 4'(SETTLE);

  state_t            state;
  state_t            state_nxt;

  logic [1:0]        vec;
  logic [PASS_W-1:0] sweep;
  logic [PASS_W-1:0] passes_q;
  logic [3:0]        fail_map_q;
  logic [7:0]        err_count_q;
  logic              pass_q;
  logic              a_q;
  logic              b_q;

  logic              timer_load;
  logic              timer_dec;
  logic              timer_expired;

  logic              miscompare;
  logic              last_vec;
  logic              last_sweep;
  logic [7:0]        err_nxt;

  bist_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_V),
    .dec      (timer_dec),
    .expired  (timer_expired)
  );

  assign miscompare = (bus.y != TRUTH[vec]);
  assign last_vec   = (vec == 2'd3);
  // passes_q is never zero after accept, so passes_q - 1 cannot underflow.
  assign last_sweep = (sweep == passes_q - ONE);
  assign err_nxt    = miscompare ? sat_inc8(err_count_q) : err_count_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        timer_load = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        timer_dec = 1'b1;
        if (timer_expired) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (last_vec && last_sweep) state_nxt = ST_FINISH;
        else                        state_nxt = ST_APPLY;
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Run datapath: vector/sweep indices, stimulus, and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec         <= 2'd0;
      sweep       <= '0;
      passes_q    <= '0;
      fail_map_q  <= 4'd0;
      err_count_q <= 8'd0;
      pass_q      <= 1'b0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            passes_q    <= (bus.passes == '0) ? ONE : bus.passes;
            fail_map_q  <= 4'd0;
            err_count_q <= 8'd0;
            pass_q      <= 1'b0;
            vec         <= 2'd0;
            sweep       <= '0;
          end
        end
        ST_APPLY: begin
          {a_q, b_q} <= vec;
        end
        ST_SAMPLE: begin
          if (miscompare) fail_map_q[vec] <= 1'b1;
          err_count_q <= err_nxt;
          if (last_vec && last_sweep) begin
            // Resolve the verdict here, including this final sample, so pass
            // is already valid in the FINISH cycle alongside done.
            pass_q <= (err_nxt == 8'd0);
          end else if (last_vec) begin
            vec   <= 2'd0;
            sweep <= sweep + ONE;
          end else begin
            vec <= vec + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy      = (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_SAMPLE);
  assign bus.done      = (state == ST_FINISH);
  assign bus.pass      = pass_q;
  assign bus.fail_map  = fail_map_q;
  assign bus.err_count = err_count_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl driving a behavioural NAND with injectable stuck-at faults.
// Ports: none; instantiates the interface, the sequencer and the gate model.
// Outputs are sampled on the falling edge; inputs are changed on the falling edge.
module tb_gate_bist_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   fault;     // 0 = good NAND, 1 = y stuck at 1, 2 = y stuck at 0

  gate_bist_ctrl_if #(.PASS_W(8)) bus ();

  gate_bist_ctrl #(
    .TRUTH  (4'b0111),
    .SETTLE (2),
    .PASS_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Gate under test.
  assign bus.y = (fault == 1) ? 1'b1 :
                 (fault == 2) ? 1'b0 : ~(bus.a & bus.b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one run and wait for done. cyc is the cycle on which done is seen,
  // counting the accept cycle as cycle 1. pulse_at > 0 raises start for one
  // cycle at that point to show mid-run requests are ignored.
  task automatic run_bist(input logic [7:0] n, input int pulse_at, input int limit, output int cyc);
    @(negedge clk);
    bus.passes = n;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check_val("busy_after_accept", bus.busy, 1);
    check_val("pass_cleared", bus.pass, 0);
    check_val("err_cleared", bus.err_count, 0);
    while (!bus.done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == pulse_at);
    end
    bus.start = 1'b0;
    check_val("done_seen", bus.done, 1);
    check_val("busy_at_done", bus.busy, 0);
  endtask

  int cyc;
  logic saw_done;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    fault      = 0;
    bus.start  = 1'b0;
    bus.passes = 8'd0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check_val("rst_a", bus.a, 0);
    check_val("rst_b", bus.b, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_pass", bus.pass, 0);
    check_val("rst_fail_map", bus.fail_map, 0);
    check_val("rst_err_count", bus.err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good NAND, one pass: done on cycle 17.
    run_bist(8'd1, 0, 200, cyc);
    check_val("good_done_cycle", cyc, 17);
    check_val("good_pass", bus.pass, 1);
    check_val("good_fail_map", bus.fail_map, 4'b0000);
    check_val("good_err_count", bus.err_count, 0);
    check_val("good_a_hold", bus.a, 1);
    check_val("good_b_hold", bus.b, 1);
    @(negedge clk);
    check_val("good_done_pulse", bus.done, 0);
    check_val("good_pass_held", bus.pass, 1);

    // y stuck at 1: only vector 11 miscompares.
    fault = 1;
    run_bist(8'd1, 0, 200, cyc);
    check_val("s1_done_cycle", cyc, 17);
    check_val("s1_pass", bus.pass, 0);
    check_val("s1_fail_map", bus.fail_map, 4'b1000);
    check_val("s1_err_count", bus.err_count, 1);
    @(negedge clk);
    check_val("s1_pass_held", bus.pass, 0);
    check_val("s1_fail_map_held", bus.fail_map, 4'b1000);

    // y stuck at 0, three passes: 3 errors per sweep, 48-cycle run.
    fault = 2;
    run_bist(8'd3, 0, 200, cyc);
    check_val("s0x3_done_cycle", cyc, 49);
    check_val("s0x3_pass", bus.pass, 0);
    check_val("s0x3_fail_map", bus.fail_map, 4'b0111);
    check_val("s0x3_err_count", bus.err_count, 9);

    // passes=0 acts as 1; a start pulse mid-run changes nothing.
    fault = 0;
    run_bist(8'd0, 6, 200, cyc);
    check_val("p0_done_cycle", cyc, 17);
    check_val("p0_pass", bus.pass, 1);
    check_val("p0_fail_map", bus.fail_map, 4'b0000);
    check_val("p0_err_count", bus.err_count, 0);
    @(negedge clk);
    check_val("p0_no_restart", bus.busy, 0);

    // y stuck at 0, 255 passes: 765 miscompares saturate at 255.
    fault = 2;
    run_bist(8'd255, 0, 5000, cyc);
    check_val("sat_done_cycle", cyc, 4081);
    check_val("sat_err_count", bus.err_count, 255);
    check_val("sat_fail_map", bus.fail_map, 4'b0111);
    check_val("sat_pass", bus.pass, 0);

    // Reset during WAIT of vector 10.
    fault = 0;
    @(negedge clk);
    bus.passes = 8'd1;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    // Accept cycle is 1; vector 10 is applied on cycle 9, waits on 10-11.
    repeat (9) @(negedge clk);
    check_val("mid_a_vec2", bus.a, 1);
    check_val("mid_b_vec2", bus.b, 0);
    check_val("mid_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_a", bus.a, 0);
    check_val("arst_b", bus.b, 0);
    check_val("arst_busy", bus.busy, 0);
    check_val("arst_done", bus.done, 0);
    check_val("arst_pass", bus.pass, 0);
    check_val("arst_fail_map", bus.fail_map, 0);
    check_val("arst_err_count", bus.err_count, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (bus.done) saw_done = 1'b1;
    end
    check_val("arst_no_done", saw_done, 0);

    // Clean run after the abort.
    run_bist(8'd1, 0, 200, cyc);
    check_val("post_done_cycle", cyc, 17);
    check_val("post_pass", bus.pass, 1);
    check_val("post_fail_map", bus.fail_map, 4'b0000);
    check_val("post_err_count", bus.err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Self-test sequencer for a 2-input combinational gate such as the team's NAND gate. On a start request it drives the gate's `a`/`b` inputs through all four input combinations for a programmable number of sweeps. It waits a fixed settle time before sampling `y`, compares the sample against a parameterised truth table, and reports a pass flag, a per-vector fail bitmap and a saturating error count. It sits between a test/control register block and the gate under test, and replaces the hand-written stimulus sequence of the gate-level benches with a synthesizable controller.

## Interface
- `TRUTH`, 4'b0111: expected `y` for each vector; bit index = {a,b}. The default is the NAND truth table.
- `SETTLE`, 2: cycles between driving a vector and sampling `y`; legal range 1..15.
- `PASS_W`, 8: width of the `passes` input.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `passes` in PASS_W: number of full 4-vector sweeps; captured on start accept; 0 is treated as 1.
- `busy` out 1: high from the cycle after start accept through the last SAMPLE cycle.
- `done` out 1: single-cycle pulse at run end.
- `pass` out 1: run result; valid from `done` onward and held until the next start accept.
- `fail_map` out 4: sticky per-vector miscompare flags; bit index = {a,b}.
- `err_count` out 8: total miscompares, saturating at 255.
- `a`, `b` out 1: registered stimulus to the gate under test.
- `y` in 1: gate output under test.

## Operation
- FSM states: IDLE, APPLY, WAIT, SAMPLE, FINISH.
- IDLE, with `start`=1: capture `passes` (0 becomes 1), clear `fail_map`, `err_count`, `pass`, `vec`, `sweep`, then go to APPLY.
- IDLE, with `start`=0: stay in IDLE. `start` in any other state is ignored.
- APPLY: `{a,b}` <= `vec`; load the settle counter with SETTLE; go to WAIT.
- WAIT: decrement the counter; go to SAMPLE when the counter reaches 1 (SETTLE cycles in WAIT).
- SAMPLE: compare `y` against `TRUTH[vec]`. On mismatch, set `fail_map[vec]` and increment `err_count` unless it is already 255. Then:
  - If `vec`=3 and `sweep`=passes-1: go to FINISH.
  - Else if `vec`=3: set `vec`=0, increment `sweep`, go to APPLY.
  - Else: increment `vec`, go to APPLY.
- FINISH: `done`=1 and `pass`=(`err_count`==0 including this run's final sample); return to IDLE.
- `a`/`b` hold their last driven vector (1,1) after the run; they return to 0 only on reset.
- Vector order within a sweep is fixed: 00, 01, 10, 11.

## Timing
- Reset values: state=IDLE; `a`=`b`=0; `busy`=`done`=`pass`=0; `fail_map`=0; `err_count`=0.
- Each vector takes SETTLE+2 cycles (APPLY, WAIT×SETTLE, SAMPLE).
- A run takes N×4×(SETTLE+2) cycles from the start-accept edge to the last SAMPLE, where N is the effective pass count; `done` follows one cycle later.
- `y` is sampled SETTLE+1 edges after `a`/`b` change.
- Asserting `rst_n` mid-run aborts immediately to reset values; no `done` is produced.
- `start` held high continuously produces back-to-back runs, one IDLE cycle apart.

## Structure
- Package `gate_bist_pkg` holds:
  - the state enum;
  - truth-table constants: NAND 4'b0111, AND 4'b1000, OR 4'b1110, XOR 4'b0110, NOR 4'b0001.
- Sub-module `bist_settle_timer` is a loadable 4-bit down-counter with a `expired` output, instantiated once.
- Everything else lives in `gate_bist_ctrl`. The bench pairs it with the existing NAND gate module.

## Test plan
- NAND DUT, TRUTH=0111, SETTLE=2, passes=1, start: `done` at cycle 17 after accept; `pass`=1, `fail_map`=0000, `err_count`=0.
- `y` stuck at 1, passes=1: `pass`=0, `fail_map`=1000, `err_count`=1.
- `y` stuck at 0, passes=3: `fail_map`=0111, `err_count`=9, run length 48 cycles.
- passes=0 with a good NAND: behaves as passes=1 (16 cycles, `pass`=1). Pulse `start` mid-run: no restart and counts unchanged.
- `y` stuck at 0, passes=255: `err_count` saturates at 255 and does not wrap; `fail_map`=0111.
- `rst_n` low during the WAIT state of vector 2: all outputs go to reset values asynchronously; no `done`; a new start runs cleanly.
